// File: rtl/video_pkg.sv
// Shared video-subsystem definitions: peripheral address windows, map geometry,
// the fill-engine state encoding and the tile-map address helper.
package video_pkg;

    localparam logic [31:0] VIDREG_BASE  = 32'h0500_0000;
    localparam logic [31:0] TEXMEM_BASE  = 32'h0510_0000;
    localparam logic [31:0] TILEMEM_BASE = 32'h0520_0000;

    localparam int MAP_BITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Word address of map cell (row, col); the window base is OR-ed, not added.
    function automatic logic [31:0] tile_addr(input logic [31:0]         base,
                                              input logic [MAP_BITS-1:0] row,
                                              input logic [MAP_BITS-1:0] col);
        tile_addr = base | {{(32 - 2*MAP_BITS - 2){1'b0}}, row, col, 2'b00};
    endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major rectangle scanner: column offset is the inner counter, row offset
// the outer one. o_last flags the final cell of the loaded rectangle.
module rect_scan_counter #(
    parameter int MAP_BITS = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_load,
    input  logic                i_adv,
    input  logic [MAP_BITS:0]   i_w,
    input  logic [MAP_BITS:0]   i_h,
    output logic [MAP_BITS-1:0] o_col,
    output logic [MAP_BITS-1:0] o_row,
    output logic                o_last
);

    logic [MAP_BITS-1:0] r_col;
    logic [MAP_BITS-1:0] r_row;
    logic [MAP_BITS-1:0] r_col_max;
    logic [MAP_BITS-1:0] r_row_max;
    logic                w_col_end;
    logic                w_row_end;

    assign w_col_end = (r_col == r_col_max);
    assign w_row_end = (r_row == r_row_max);
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_last    = w_col_end && w_row_end;

    // Storing size-1 in MAP_BITS bits maps a full-width 2^MAP_BITS onto all-ones.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col     <= '0;
            r_row     <= '0;
            r_col_max <= '0;
            r_row_max <= '0;
        end else if (i_load) begin
            r_col     <= '0;
            r_row     <= '0;
            r_col_max <= i_w[MAP_BITS-1:0] - MAP_BITS'(1);
            r_row_max <= i_h[MAP_BITS-1:0] - MAP_BITS'(1);
        end else if (i_adv) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + MAP_BITS'(1);
            end else begin
                r_col <= r_col + MAP_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/tile_fill_dma.sv
// Bus-master engine that fills a rectangle of the tile map with constant or
// incrementing tile indices through the tile-memory window.
module tile_fill_dma #(
    parameter logic [31:0] BASE_ADDR = 32'h0520_0000,
    parameter int          MAP_BITS  = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [MAP_BITS-1:0] cmd_x,
    input  logic [MAP_BITS-1:0] cmd_y,
    input  logic [MAP_BITS:0]   cmd_w,
    input  logic [MAP_BITS:0]   cmd_h,
    input  logic [MAP_BITS-1:0] cmd_tile,
    input  logic                cmd_inc,
    output logic                busy,
    output logic                done,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    output logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_wdata
);

    import video_pkg::*;

    localparam logic [MAP_BITS:0] MAP_DIM = {1'b1, {MAP_BITS{1'b0}}};

    state_t              r_state;
    logic [MAP_BITS-1:0] r_x0;
    logic [MAP_BITS-1:0] r_y0;
    logic [MAP_BITS-1:0] r_tile;
    logic                r_inc;

    logic                w_accept;
    logic                w_adv;
    logic                w_last;
    logic                w_empty;
    logic [MAP_BITS:0]   w_w;
    logic [MAP_BITS:0]   w_h;
    logic [MAP_BITS-1:0] w_col_off;
    logic [MAP_BITS-1:0] w_row_off;
    logic [MAP_BITS-1:0] w_col;
    logic [MAP_BITS-1:0] w_row;

    // Clamping to the map size guarantees wrapped columns/rows never revisit a cell.
    assign w_w      = (cmd_w > MAP_DIM) ? MAP_DIM : cmd_w;
    assign w_h      = (cmd_h > MAP_DIM) ? MAP_DIM : cmd_h;
    assign w_empty  = (w_w == '0) || (w_h == '0);

    assign cmd_ready = (r_state == IDLE) && resetn;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_adv     = (r_state == WRITE) && mem_ready;

    rect_scan_counter #(
        .MAP_BITS (MAP_BITS)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_accept),
        .i_adv  (w_adv),
        .i_w    (w_w),
        .i_h    (w_h),
        .o_col  (w_col_off),
        .o_row  (w_row_off),
        .o_last (w_last)
    );

    // Fixed-width adds wrap column and row independently, with no carry between them.
    assign w_col = r_x0 + w_col_off;
    assign w_row = r_y0 + w_row_off;

    // NOTE: bus outputs decode from registered state, so they are stable while
    // held and read as zero outside WRITE without extra output registers.
    assign mem_valid = (r_state == WRITE);
    assign mem_addr  = mem_valid ? tile_addr(BASE_ADDR, w_row, w_col) : '0;
    assign mem_wdata = mem_valid ? {{(32 - MAP_BITS){1'b0}}, r_tile} : '0;
    assign mem_wstrb = mem_valid ? 4'b0001 : 4'b0000;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_tile  <= '0;
            r_inc   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x0    <= cmd_x;
                        r_y0    <= cmd_y;
                        r_tile  <= cmd_tile;
                        r_inc   <= cmd_inc;
                        r_state <= w_empty ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (r_inc) r_tile <= r_tile + MAP_BITS'(1);
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_fill_dma.sv
// Randomised and directed bench for tile_fill_dma; a queue-based reference
// model lists the expected writes of each command in row-major order.
module tb_tile_fill_dma;

    localparam logic [31:0] BASE = 32'h0520_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_x = '0;
    logic [5:0]  cmd_y = '0;
    logic [6:0]  cmd_w = '0;
    logic [6:0]  cmd_h = '0;
    logic [5:0]  cmd_tile = '0;
    logic        cmd_inc = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;

    int n_checks   = 0;
    int n_errors   = 0;
    int xfer_count = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: 3 wait cycles per write
    int hold_cnt   = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          seen[4096];
    bit          prev_wait = 1'b0;
    bit          rdy;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_strb;

    tile_fill_dma dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_tile  (cmd_tile),
        .cmd_inc   (cmd_inc),
        .busy      (busy),
        .done      (done),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus responder: decides mem_ready on the falling edge and scores each
    // transfer that the next rising edge will complete.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_wait = 1'b0;
            hold_cnt  = 0;
            mem_ready = 1'b0;
        end else begin
            if (prev_wait) begin
                check("valid_held", 32'(mem_valid), 32'd1);
                if (mem_valid) begin
                    check("addr_stable", mem_addr, p_addr);
                    check("data_stable", mem_wdata, p_data);
                    check("strb_stable", 32'(mem_wstrb), 32'(p_strb));
                end
            end
            if (mem_valid) begin
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (hold_cnt == 3);
                endcase
                hold_cnt = rdy ? 0 : hold_cnt + 1;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            mem_ready = rdy;
            if (mem_valid && rdy) begin
                xfer_count++;
                check("write_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) begin
                    check("addr", mem_addr, exp_addr.pop_front());
                    check("data", mem_wdata, exp_data.pop_front());
                end
                check("wstrb", 32'(mem_wstrb), 32'h1);
                check("no_dup_addr", 32'(seen[mem_addr[13:2]]), 32'd0);
                seen[mem_addr[13:2]] = 1'b1;
            end
            prev_wait = mem_valid && !rdy;
            p_addr    = mem_addr;
            p_data    = mem_wdata;
            p_strb    = mem_wstrb;
        end
    end

    // Reference model: expected write list straight from the fill rules.
    task automatic model_cmd(input int x, input int y, input int w, input int h,
                             input int tile, input bit inc);
        int wc = (w > 64) ? 64 : w;
        int hc = (h > 64) ? 64 : h;
        int t  = tile;
        for (int r = 0; r < hc; r++) begin
            for (int c = 0; c < wc; c++) begin
                exp_addr.push_back(BASE | 32'((((y + r) % 64) << 8) | (((x + c) % 64) << 2)));
                exp_data.push_back(32'(t));
                if (inc) t = (t + 1) % 64;
            end
        end
    endtask

    function automatic int n_writes(input int w, input int h);
        return ((w > 64) ? 64 : w) * ((h > 64) ? 64 : h);
    endfunction

    task automatic clear_seen();
        for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h,
                             input int tile, input bit inc);
        cmd_x    = 6'(x);
        cmd_y    = 6'(y);
        cmd_w    = 7'(w);
        cmd_h    = 7'(h);
        cmd_tile = 6'(tile);
        cmd_inc  = inc;
    endtask

    // Offers a command and returns one cycle after the accepting edge.
    task automatic issue(input int x, input int y, input int w, input int h,
                         input int tile, input bit inc, input bit keep_valid);
        int k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        drive_cmd(x, y, w, h, tile, inc);
        cmd_valid = 1'b1;
        @(posedge clk); #2;
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!done && lat < 10000) begin
            @(posedge clk); #2;
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic after_done();
        @(posedge clk); #2;
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(cmd_ready), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
        check("model_drained", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input int tile, input bit inc, input int exp_lat);
        int lat;
        int x0 = xfer_count;
        int nw = n_writes(w, h);
        clear_seen();
        model_cmd(x, y, w, h, tile, inc);
        issue(x, y, w, h, tile, inc, 1'b0);
        if (nw != 0) begin
            check("first_valid", 32'(mem_valid), 32'd1);
        end else begin
            check("zero_no_valid", 32'(mem_valid), 32'd0);
            check("zero_done", 32'(done), 32'd1);
        end
        wait_done(1, lat);
        if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
        check("write_count", 32'(xfer_count - x0), 32'(nw));
        after_done();
    endtask

    initial begin
        int lat;
        int x0;
        int k;

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_data", mem_wdata, 32'd0);
        check("rst_strb", 32'(mem_wstrb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #2;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single tile, then wrap on column, row and tile index.
        ready_mode = 0;
        run_cmd(3, 5, 1, 1, 9, 1'b0, 2);
        run_cmd(62, 63, 3, 2, 62, 1'b1, 7);

        // Back-pressure and zero-sized commands.
        ready_mode = 2;
        run_cmd(10, 20, 2, 1, 33, 1'b1, 9);
        ready_mode = 0;
        run_cmd(7, 7, 0, 4, 5, 1'b1, 1);
        run_cmd(7, 7, 4, 0, 5, 1'b0, 1);

        // Random commands under random back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            run_cmd($urandom_range(0, 63), $urandom_range(0, 63),
                    (i == 9) ? $urandom_range(65, 127) : $urandom_range(0, 10),
                    $urandom_range(0, 5), $urandom_range(0, 63),
                    1'($urandom_range(0, 1)), -1);
        end

        // Full screen, with an oversized second command held pending throughout.
        ready_mode = 0;
        clear_seen();
        model_cmd(0, 0, 64, 64, 0, 1'b0);
        model_cmd(0, 0, 100, 64, 0, 1'b0);
        x0 = xfer_count;
        issue(0, 0, 64, 64, 0, 1'b0, 1'b1);
        drive_cmd(0, 0, 100, 64, 0, 1'b0);
        wait_done(1, lat);
        check("full_latency", 32'(lat), 32'd4097);
        check("full_writes", 32'(xfer_count - x0), 32'd4096);
        check("pending_blocked", 32'(cmd_ready), 32'd0);
        clear_seen();
        @(posedge clk); #2;
        check("pending_offered", 32'(cmd_ready), 32'd1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        check("pending_accepted", 32'(busy), 32'd1);
        check("pending_first_valid", 32'(mem_valid), 32'd1);
        x0 = xfer_count;
        wait_done(1, lat);
        check("clamp_latency", 32'(lat), 32'd4097);
        check("clamp_writes", 32'(xfer_count - x0), 32'd4096);
        after_done();

        // Reset after the 10th transfer of an 8x8 fill.
        clear_seen();
        model_cmd(20, 30, 8, 8, 1, 1'b1);
        x0 = xfer_count;
        issue(20, 30, 8, 8, 1, 1'b1, 1'b0);
        k = 0;
        while (xfer_count - x0 < 10 && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        check("ten_transfers", 32'(xfer_count - x0), 32'd10);
        resetn = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk); #2;
        check("midrst_valid", 32'(mem_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_writes", 32'(xfer_count - x0), 32'd10);
        @(posedge clk); #2;
        check("midrst_done2", 32'(done), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #2;
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_no_done", 32'(done), 32'd0);
        run_cmd(5, 6, 3, 3, 40, 1'b1, 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
